// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the fetch-stage state encoding.
package riscv_pkg;

  // Major opcodes (inst[6:2]) for control-flow instructions
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  // True for any opcode that can redirect the front end
  function automatic logic is_ctrl_flow(input logic [4:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_next_gen.sv
// Next-PC arithmetic for the fetch stage: sequential increment, aligned
// redirect target and misalignment flag. Purely combinational.
module pc_next_gen #(
  parameter int W = 32
) (
  input  logic [W-1:0] pc_i,
  input  logic         jump_i,
  input  logic [W-1:0] target_i,
  output logic [W-1:0] next_pc_o,
  output logic [W-1:0] pc_four_o,
  output logic         misalign_o
);

  // Sequential PC wraps modulo 2^W; redirect targets are forced word aligned
  always_comb begin
    pc_four_o  = pc_i + W'(4);
    next_pc_o  = jump_i ? {target_i[W-1:2], 2'b00} : pc_four_o;
    misalign_o = jump_i && (target_i[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch stage. One request outstanding at a
// time; the returned word is buffered for decode, and fetches on the wrong
// path are squashed when execute redirects.
//
// state  | meaning
// S_BOOT | one idle cycle after reset release
// S_REQ  | request presented on imem, waiting for ready
// S_WAIT | request accepted, waiting for the response
// S_HOLD | instruction buffered and offered to decode
module fetch_pc_unit
  import riscv_pkg::*;
#(
  parameter int           W         = 32,
  parameter logic [W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [W-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_jump,
  input  logic [W-1:0] i_target,
  output logic         o_imem_valid,
  input  logic         i_imem_ready,
  output logic [W-1:0] o_imem_addr,
  input  logic         i_rsp_valid,
  input  logic [W-1:0] i_rsp_data,
  output logic         o_instr_valid,
  input  logic         i_dec_ready,
  output logic [W-1:0] o_instr,
  output logic [W-1:0] o_pc,
  output logic [W-1:0] o_pc_four,
  output logic         o_misalign
);

  fetch_state_e state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] addr_q, addr_d;
  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] opc_q, opc_d;
  logic [W-1:0] opf_q, opf_d;
  logic         kill_q, kill_d;
  logic         mis_q, mis_d;

  logic [W-1:0] next_pc;
  logic [W-1:0] pc_four;
  logic         misalign;
  logic         redirect;

  pc_next_gen #(.W(W)) u_pc_next_gen (
    .pc_i       (pc_q),
    .jump_i     (i_jump),
    .target_i   (i_target),
    .next_pc_o  (next_pc),
    .pc_four_o  (pc_four),
    .misalign_o (misalign)
  );

  // Redirects are ignored during the boot cycle
  assign redirect = i_jump && (state_q != S_BOOT);

  // Next-state logic. addr_q is a separate copy of the PC so a presented
  // request never changes under a redirect before it is accepted.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    opf_d   = opf_q;
    kill_d  = kill_q;
    mis_d   = 1'b0;

    if (redirect) begin
      pc_d  = next_pc;
      mis_d = misalign;
    end

    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        addr_d  = pc_q;
      end
      S_REQ: begin
        // The in-flight request stays; its response will be dropped instead
        if (redirect) kill_d = 1'b1;
        if (i_imem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_rsp_valid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
            addr_d  = pc_d;
          end else begin
            instr_d = i_rsp_data;
            opc_d   = pc_q;
            opf_d   = pc_four;
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        // Redirect outranks decode accepting the buffered word
        if (redirect) begin
          state_d = S_REQ;
          addr_d  = pc_d;
        end else if (i_dec_ready) begin
          pc_d    = pc_four;
          addr_d  = pc_four;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= NOP_INSTR;
      opc_q   <= RESET_PC;
      opf_q   <= RESET_PC + W'(4);
      kill_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      opf_q   <= opf_d;
      kill_q  <= kill_d;
      mis_q   <= mis_d;
    end
  end

  // A wrong-path word is never offered in the cycle of the redirect
  always_comb begin
    o_imem_valid  = (state_q == S_REQ);
    o_imem_addr   = addr_q;
    o_instr_valid = (state_q == S_HOLD) && !i_jump;
    o_instr       = instr_q;
    o_pc          = opc_q;
    o_pc_four     = opf_q;
    o_misalign    = mis_q;
  end

endmodule
